uart_pkt_bridge: RTL and testbench
==================================

# uart_pkt_bridge

Parametrised UART packet-protocol engine between the UART RX/TX byte streams and the accelerator's CSR file and tile buffers. It replaces the pass-through byte-to-CSR wiring with framed, CRC-checked commands: CSR write, CSR read and multi-channel buffer write, each returning a response byte stream. It sits in the accelerator top level, fed by `uart_rx` and driving `uart_tx`, `csr` and the activation/weight buffer write ports.

## Interface
- `DATA_W`, 32: CSR data width; multiple of 8, 8..64.
- `ADDR_W`, 8: CSR address width; at most 8.
- `N_BUF`, 2: number of buffer write channels, 1..8. Channel 0 is activation, channel 1 is weight.
- `BUF_AW`, 6: buffer write address width; at most 8.
- `BUF_DW`, 64: buffer word width; multiple of 8, 8..256.
- `CRC_EN`, 1: 1 means every packet carries a trailing CRC-8 byte; 0 means no CRC byte.
- `TO_CYC`, 65535: inter-byte timeout in clk cycles; 0 disables the timeout.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle pulse; `rx_data` is valid in that cycle.
- `rx_err` in 1: frame or parity error pulse from the UART receiver.
- `tx_data` out 8: byte to transmit.
- `tx_valid` out 1: transmit request.
- `tx_ready` in 1: the transmitter accepts the byte when `tx_valid` and `tx_ready` are both high.
- `csr_wen`, `csr_ren` out 1: one-cycle CSR strobes.
- `csr_addr` out ADDR_W: CSR address.
- `csr_wdata` out DATA_W: CSR write data.
- `csr_rdata` in DATA_W: CSR read data; valid one cycle after `csr_ren`.
- `buf_we` out N_BUF: one-hot, one-cycle buffer write strobe.
- `buf_waddr` out BUF_AW: buffer write address.
- `buf_wdata` out BUF_DW: buffer write data.
- `crc_err` out 1: one-cycle pulse on CRC mismatch.
- `illegal_cmd` out 1: one-cycle pulse on an unknown opcode or bad channel.
- `timeout` out 1: one-cycle pulse when a packet is aborted by the inter-byte timeout.
- `busy` out 1: high in every state except IDLE.

## Operation
Packet framing: opcode byte, then fields, then an optional CRC byte. Multi-byte fields are little-endian, so the first byte received lands in bits [7:0].
- `0x01` CSR_WR: addr byte, DATA_W/8 data bytes, [crc]. Response: `0xA5`.
- `0x02` CSR_RD: addr byte, [crc]. Response: DATA_W/8 bytes of `csr_rdata`, LSB first.
- `0x10|ch` BUF_WR, with ch < N_BUF: addr byte, BUF_DW/8 data bytes, [crc]. Response: `0xA5`.
- Address bytes are truncated to ADDR_W or BUF_AW bits.
- CRC-8 uses polynomial 0x07, init 0x00, no reflection, and covers the opcode through the last field byte.
- Any other opcode, or ch >= N_BUF: pulse `illegal_cmd`, respond `0x5A`/`0xEE` → respond `0xEE`. No further bytes are consumed for that packet.
- CRC mismatch: pulse `crc_err`, respond `0x5A`, perform no CSR or buffer access.

State machine:
- IDLE → OP on `rx_valid` (the opcode byte is decoded in the same cycle).
- OP → ADDR → DATA (CSR_RD skips DATA) → CRC (skipped if CRC_EN=0) → EXEC.
- EXEC issues the write strobe or `csr_ren`, then goes to TX for writes or RDW for reads.
- RDW captures `csr_rdata` into the response shift register, then goes to TX.
- TX sends the response bytes and returns to IDLE after the last handshake.

Boundary conditions:
- `rx_err` in any receive state other than IDLE: abort to IDLE with no response and no access. `rx_err` in IDLE is ignored.
- The timeout counter clears on every `rx_valid`. When it reaches TO_CYC in a receive state (ADDR, DATA, CRC): pulse `timeout`, abort to IDLE, send no response.
- `rx_valid` during EXEC, RDW or TX: the byte is dropped. No queueing.
- `rx_valid` and `rx_err` in the same cycle: `rx_err` wins and the byte is discarded.
- Reset mid-packet or mid-response: immediate return to IDLE; the partial packet is lost.

## Timing
- Reset values: every output is 0, including `tx_data`, `csr_addr`, `csr_wdata`, `buf_waddr` and `buf_wdata`. The state is IDLE.
- Write strobes (`csr_wen` / `buf_we`): high exactly one cycle, at cycle T+1, where T is the cycle of the final packet byte. Address and data are stable in that cycle.
- Read: `csr_ren` at T+1, `csr_rdata` captured at T+2, `tx_valid` rises at T+3.
- Write acknowledge: `tx_valid` rises at T+2.
- The error/status pulses `crc_err`, `illegal_cmd` and `timeout` are one cycle wide, at T+1 of the triggering event.
- TX handshake:
  - `tx_data` is held stable while `tx_valid` is high and `tx_ready` is low.
  - The next byte is presented the cycle after a handshake.
  - `tx_valid` does not depend combinationally on `tx_ready`.
  - `tx_valid` drops the cycle after the last handshake.
- IDLE is re-entered the cycle after the final handshake. A new opcode is accepted in that cycle.

## Test plan
- CSR_WR `01 10 EF BE AD DE <crc>` → one `csr_wen` pulse, `csr_addr`=0x10, `csr_wdata`=0xDEADBEEF, response `A5`.
- Same packet with the CRC bit0 flipped → no `csr_wen`, one `crc_err` pulse, response `5A`.
- CSR_RD `02 04 <crc>` with `csr_rdata`=0x12345678 and `tx_ready` low for 3 cycles per byte → one `csr_ren`, addr 0x04, response `78 56 34 12`, `tx_data` stable throughout each stall.
- BUF_WR `11 03 01..08 <crc>` (N_BUF=2) → `buf_we`=2'b10, `buf_waddr`=3, `buf_wdata`=0x0807060504030201, response `A5`.
- Opcodes `7F` then `12` (N_BUF=2) → two `illegal_cmd` pulses, two `EE` responses. A following valid CSR_WR completes normally.
- Aborts (TO_CYC=100, CRC_EN=0 run included):
  - Stall mid-DATA for 100 cycles → `timeout` pulse, no access, no response.
  - `rx_err` mid-ADDR → abort with no access and no response.
  - `rst` asserted mid-TX → all outputs 0 immediately.
  - After each abort, the next packet is processed correctly.

Source files
------------

// File: rtl/uart_pkt_bridge.sv
// UART packet bridge: decodes framed, optionally CRC-8 protected CSR and buffer
// commands from the UART receive stream and returns a response byte stream.
module uart_pkt_bridge #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int N_BUF  = 2,
    parameter int BUF_AW = 6,
    parameter int BUF_DW = 64,
    parameter int CRC_EN = 1,
    parameter int TO_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_err,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              csr_wen,
    output logic              csr_ren,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [DATA_W-1:0] csr_wdata,
    input  logic [DATA_W-1:0] csr_rdata,
    output logic [N_BUF-1:0]  buf_we,
    output logic [BUF_AW-1:0] buf_waddr,
    output logic [BUF_DW-1:0] buf_wdata,
    output logic              crc_err,
    output logic              illegal_cmd,
    output logic              timeout,
    output logic              busy
);

    localparam int CSR_BYTES = DATA_W / 8;
    localparam int BUF_BYTES = BUF_DW / 8;

    typedef enum logic [2:0] {IDLE, OP, ADDR, DATA, CRC, EXEC, RDW, TX} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              op_wr;
    logic              op_rd;
    logic              op_buf;
    logic              op_bad;
    logic [2:0]        op_ch;
    logic [7:0]        crc_q;
    logic [5:0]        byte_cnt;
    logic [DATA_W-1:0] resp_q;
    logic [3:0]        resp_cnt;
    logic [31:0]       to_cnt;

    logic rx_byte;
    logic rcv;
    logic to_hit;
    logic last_data;
    logic dec_wr;
    logic dec_rd;
    logic dec_buf;

    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // A byte flagged with rx_err is never consumed; the error takes precedence.
    assign rx_byte   = rx_valid && !rx_err;
    assign rcv       = (state == ADDR) || (state == DATA) || (state == CRC);
    assign to_hit    = rcv && (TO_CYC != 0) && !rx_valid && (to_cnt == 32'(TO_CYC - 1));
    assign last_data = (byte_cnt == (op_buf ? 6'(BUF_BYTES - 1) : 6'(CSR_BYTES - 1)));
    assign dec_wr    = (rx_data == 8'h01);
    assign dec_rd    = (rx_data == 8'h02);
    assign dec_buf   = (rx_data[7:4] == 4'h1) && (int'(rx_data[3:0]) < N_BUF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (rx_byte) state_nxt = OP;
            OP: begin
                if (rx_err)      state_nxt = IDLE;
                else if (op_bad) state_nxt = TX;
                else             state_nxt = ADDR;
            end
            ADDR: begin
                if (rx_err || to_hit) state_nxt = IDLE;
                else if (rx_byte) begin
                    if (!op_rd)           state_nxt = DATA;
                    else if (CRC_EN != 0) state_nxt = CRC;
                    else                  state_nxt = EXEC;
                end
            end
            DATA: begin
                if (rx_err || to_hit) state_nxt = IDLE;
                else if (rx_byte && last_data) begin
                    if (CRC_EN != 0) state_nxt = CRC;
                    else             state_nxt = EXEC;
                end
            end
            CRC: begin
                if (rx_err || to_hit) state_nxt = IDLE;
                else if (rx_byte)     state_nxt = (rx_data == crc_q) ? EXEC : TX;
            end
            EXEC: state_nxt = op_rd ? RDW : TX;
            RDW:  state_nxt = TX;
            TX:   if (tx_ready && resp_cnt == 4'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        tx_valid    = (state == TX);
        tx_data     = resp_q[7:0];
        csr_wen     = (state == EXEC) && op_wr;
        csr_ren     = (state == EXEC) && op_rd;
        buf_we      = ((state == EXEC) && op_buf) ? (N_BUF'(1) << op_ch) : '0;
        illegal_cmd = (state == OP) && op_bad;
    end

    // Multi-byte fields shift in from the top so the first byte ends up in [7:0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr     <= 1'b0;
            op_rd     <= 1'b0;
            op_buf    <= 1'b0;
            op_bad    <= 1'b0;
            op_ch     <= '0;
            crc_q     <= '0;
            byte_cnt  <= '0;
            resp_q    <= '0;
            resp_cnt  <= '0;
            to_cnt    <= '0;
            csr_addr  <= '0;
            csr_wdata <= '0;
            buf_waddr <= '0;
            buf_wdata <= '0;
            crc_err   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            crc_err <= 1'b0;
            timeout <= to_hit && !rx_err;
            to_cnt  <= (rx_valid || !rcv) ? 32'd0 : to_cnt + 32'd1;
            case (state)
                IDLE: begin
                    if (rx_byte) begin
                        op_wr    <= dec_wr;
                        op_rd    <= dec_rd;
                        op_buf   <= dec_buf;
                        op_bad   <= !(dec_wr || dec_rd || dec_buf);
                        op_ch    <= rx_data[2:0];
                        crc_q    <= crc8_next(8'h00, rx_data);
                        byte_cnt <= '0;
                    end
                end
                OP: begin
                    if (op_bad) begin
                        resp_q   <= DATA_W'(8'hEE);
                        resp_cnt <= 4'd1;
                    end
                end
                ADDR: begin
                    if (rx_byte) begin
                        crc_q    <= crc8_next(crc_q, rx_data);
                        byte_cnt <= '0;
                        if (op_buf) buf_waddr <= rx_data[BUF_AW-1:0];
                        else        csr_addr  <= rx_data[ADDR_W-1:0];
                    end
                end
                DATA: begin
                    if (rx_byte) begin
                        crc_q    <= crc8_next(crc_q, rx_data);
                        byte_cnt <= byte_cnt + 6'd1;
                        if (op_buf) buf_wdata <= (buf_wdata >> 8) | (BUF_DW'(rx_data) << (BUF_DW - 8));
                        else        csr_wdata <= (csr_wdata >> 8) | (DATA_W'(rx_data) << (DATA_W - 8));
                    end
                end
                CRC: begin
                    if (rx_byte && rx_data != crc_q) begin
                        crc_err  <= 1'b1;
                        resp_q   <= DATA_W'(8'h5A);
                        resp_cnt <= 4'd1;
                    end
                end
                EXEC: begin
                    if (!op_rd) begin
                        resp_q   <= DATA_W'(8'hA5);
                        resp_cnt <= 4'd1;
                    end
                end
                RDW: begin
                    resp_q   <= csr_rdata;
                    resp_cnt <= 4'(CSR_BYTES);
                end
                TX: begin
                    if (tx_ready) begin
                        resp_q   <= resp_q >> 8;
                        resp_cnt <= resp_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pkt_bridge.sv
// Directed bench for uart_pkt_bridge: a CRC-enabled instance and a CRC-less
// instance, both with a 100-cycle inter-byte timeout, sharing one RX driver.
`timescale 1ns/1ps
module tb_uart_pkt_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_err = 1'b0;
    logic        tx_ready = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] csr_rdata = 32'h0;

    int checks = 0;
    int errors = 0;
    int stall_bad = 0;

    always #5 clk = ~clk;

    logic        rx_valid_a, rx_valid_b, rx_err_a, rx_err_b;
    logic [7:0]  tx_data_a, tx_data_b;
    logic        tx_valid_a, tx_valid_b;
    logic        csr_wen_a, csr_wen_b, csr_ren_a, csr_ren_b;
    logic [7:0]  csr_addr_a, csr_addr_b;
    logic [31:0] csr_wdata_a, csr_wdata_b;
    logic [1:0]  buf_we_a, buf_we_b;
    logic [5:0]  buf_waddr_a, buf_waddr_b;
    logic [63:0] buf_wdata_a, buf_wdata_b;
    logic        crc_err_a, crc_err_b, illegal_cmd_a, illegal_cmd_b;
    logic        timeout_a, timeout_b, busy_a, busy_b;

    assign rx_valid_a = rx_valid & ~sel;
    assign rx_valid_b = rx_valid & sel;
    assign rx_err_a   = rx_err & ~sel;
    assign rx_err_b   = rx_err & sel;

    uart_pkt_bridge #(.CRC_EN(1), .TO_CYC(100)) dut_a (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid_a), .rx_err(rx_err_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
        .csr_wen(csr_wen_a), .csr_ren(csr_ren_a), .csr_addr(csr_addr_a),
        .csr_wdata(csr_wdata_a), .csr_rdata(csr_rdata),
        .buf_we(buf_we_a), .buf_waddr(buf_waddr_a), .buf_wdata(buf_wdata_a),
        .crc_err(crc_err_a), .illegal_cmd(illegal_cmd_a), .timeout(timeout_a), .busy(busy_a)
    );

    uart_pkt_bridge #(.CRC_EN(0), .TO_CYC(100)) dut_b (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid_b), .rx_err(rx_err_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready),
        .csr_wen(csr_wen_b), .csr_ren(csr_ren_b), .csr_addr(csr_addr_b),
        .csr_wdata(csr_wdata_b), .csr_rdata(csr_rdata),
        .buf_we(buf_we_b), .buf_waddr(buf_waddr_b), .buf_wdata(buf_wdata_b),
        .crc_err(crc_err_b), .illegal_cmd(illegal_cmd_b), .timeout(timeout_b), .busy(busy_b)
    );

    logic [62:0] outs_a, outs_b;
    assign outs_a = {tx_data_a, tx_valid_a, csr_wen_a, csr_ren_a, csr_addr_a, csr_wdata_a,
                     buf_we_a, buf_waddr_a, crc_err_a, illegal_cmd_a, timeout_a, busy_a};
    assign outs_b = {tx_data_b, tx_valid_b, csr_wen_b, csr_ren_b, csr_addr_b, csr_wdata_b,
                     buf_we_b, buf_waddr_b, crc_err_b, illegal_cmd_b, timeout_b, busy_b};

    logic        tx_valid_s, csr_wen_s;
    logic [7:0]  tx_data_s, csr_addr_s;
    logic [31:0] csr_wdata_s;
    assign tx_valid_s  = sel ? tx_valid_b  : tx_valid_a;
    assign tx_data_s   = sel ? tx_data_b   : tx_data_a;
    assign csr_wen_s   = sel ? csr_wen_b   : csr_wen_a;
    assign csr_addr_s  = sel ? csr_addr_b  : csr_addr_a;
    assign csr_wdata_s = sel ? csr_wdata_b : csr_wdata_a;

    // Event counters sampled mid-cycle, away from the active edge.
    int wen_a = 0, ren_a = 0, bwe_a = 0, crc_a = 0, ill_a = 0, to_a = 0, txc_a = 0;
    int wen_b = 0, to_b = 0, txc_b = 0;
    always @(negedge clk) begin
        if (csr_wen_a)        wen_a++;
        if (csr_ren_a)        ren_a++;
        if (buf_we_a != 2'b0) bwe_a++;
        if (crc_err_a)        crc_a++;
        if (illegal_cmd_a)    ill_a++;
        if (timeout_a)        to_a++;
        if (tx_valid_a)       txc_a++;
        if (csr_wen_b)        wen_b++;
        if (timeout_b)        to_b++;
        if (tx_valid_b)       txc_b++;
    end

    function automatic logic [7:0] crc8_model(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ b[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick(3);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    // Sends pkt bytes (byte 0 in bits [7:0]); returns in the cycle after the last byte.
    task automatic apply_stimulus(input logic [95:0] pkt, input int len, input bit with_crc,
                                  input logic [7:0] flip);
        logic [7:0] crc;
        crc = 8'h00;
        for (int i = 0; i < len; i++) begin
            crc = crc8_model(crc, pkt[8*i +: 8]);
            send_byte(pkt[8*i +: 8]);
        end
        if (with_crc) send_byte(crc ^ flip);
    endtask

    task automatic get_resp(input int n, input int stall, output logic [31:0] data);
        logic [7:0] hold;
        data = '0;
        for (int k = 0; k < n; k++) begin
            for (int w = 0; w < 50 && !tx_valid_s; w++) tick(1);
            if (!tx_valid_s) break;
            hold = tx_data_s;
            for (int s = 0; s < stall; s++) begin
                tick(1);
                if (!tx_valid_s || tx_data_s !== hold) stall_bad++;
            end
            data[8*k +: 8] = tx_data_s;
            tx_ready = 1'b1;
            tick(1);
            tx_ready = 1'b0;
        end
    endtask

    task automatic write_ok(input string tag, input logic [7:0] addr, input logic [31:0] data);
        logic [31:0] r;
        apply_stimulus(96'({data, addr, 8'h01}), 6, !sel, 8'h00);
        check_output({tag, "_wen"}, 64'(csr_wen_s), 64'd1);
        check_output({tag, "_addr"}, 64'(csr_addr_s), 64'(addr));
        check_output({tag, "_data"}, 64'(csr_wdata_s), 64'(data));
        get_resp(1, 0, r);
        check_output({tag, "_resp"}, 64'(r), 64'hA5);
    endtask

    initial begin
        logic [31:0] resp;
        int b_wen, b_ren, b_bwe, b_crc, b_ill, b_to, b_txc, b_stall;

        tick(2);
        check_output("reset_outs_a", 64'(outs_a), 64'h0);
        check_output("reset_bufdata_a", buf_wdata_a, 64'h0);
        check_output("reset_outs_b", 64'(outs_b), 64'h0);
        rst = 1'b0;
        tick(2);

        $display("[TB] CSR write");
        b_wen = wen_a;
        apply_stimulus(96'({8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h10, 8'h01}), 6, 1'b1, 8'h00);
        check_output("wr_wen_t1", 64'(csr_wen_a), 64'd1);
        check_output("wr_addr", 64'(csr_addr_a), 64'h10);
        check_output("wr_data", 64'(csr_wdata_a), 64'hDEADBEEF);
        tick(1);
        check_output("wr_txvalid_t2", 64'(tx_valid_a), 64'd1);
        get_resp(1, 0, resp);
        check_output("wr_resp", 64'(resp), 64'hA5);
        check_output("wr_count", 64'(wen_a - b_wen), 64'd1);
        check_output("wr_back_idle", 64'({tx_valid_a, busy_a}), 64'd0);

        $display("[TB] CSR write with corrupted CRC");
        b_wen = wen_a; b_crc = crc_a;
        apply_stimulus(96'({8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h10, 8'h01}), 6, 1'b1, 8'h01);
        check_output("crc_wen_t1", 64'(csr_wen_a), 64'd0);
        check_output("crc_err_t1", 64'(crc_err_a), 64'd1);
        get_resp(1, 0, resp);
        check_output("crc_resp", 64'(resp), 64'h5A);
        check_output("crc_no_write", 64'(wen_a - b_wen), 64'd0);
        check_output("crc_pulses", 64'(crc_a - b_crc), 64'd1);

        $display("[TB] CSR read with stalled transmitter");
        csr_rdata = 32'h12345678;
        b_ren = ren_a; b_stall = stall_bad;
        apply_stimulus(96'({8'h04, 8'h02}), 2, 1'b1, 8'h00);
        check_output("rd_ren_t1", 64'(csr_ren_a), 64'd1);
        check_output("rd_addr", 64'(csr_addr_a), 64'h04);
        tick(1);
        check_output("rd_txvalid_t2", 64'(tx_valid_a), 64'd0);
        tick(1);
        check_output("rd_txvalid_t3", 64'(tx_valid_a), 64'd1);
        get_resp(4, 3, resp);
        check_output("rd_resp", 64'(resp), 64'h12345678);
        check_output("rd_stall_stable", 64'(stall_bad - b_stall), 64'd0);
        check_output("rd_count", 64'(ren_a - b_ren), 64'd1);

        $display("[TB] Buffer write to weight channel");
        b_bwe = bwe_a;
        apply_stimulus(96'({8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h03, 8'h11}),
                       10, 1'b1, 8'h00);
        check_output("buf_we", 64'(buf_we_a), 64'h2);
        check_output("buf_waddr", 64'(buf_waddr_a), 64'h3);
        check_output("buf_wdata", buf_wdata_a, 64'h0807060504030201);
        get_resp(1, 0, resp);
        check_output("buf_resp", 64'(resp), 64'hA5);
        check_output("buf_count", 64'(bwe_a - b_bwe), 64'd1);

        $display("[TB] Illegal opcodes");
        b_ill = ill_a;
        apply_stimulus(96'(8'h7F), 1, 1'b0, 8'h00);
        check_output("ill7f_pulse", 64'(illegal_cmd_a), 64'd1);
        get_resp(1, 0, resp);
        check_output("ill7f_resp", 64'(resp), 64'hEE);
        apply_stimulus(96'(8'h12), 1, 1'b0, 8'h00);
        check_output("ill12_pulse", 64'(illegal_cmd_a), 64'd1);
        get_resp(1, 0, resp);
        check_output("ill12_resp", 64'(resp), 64'hEE);
        check_output("ill_count", 64'(ill_a - b_ill), 64'd2);
        write_ok("after_ill", 8'h20, 32'h11223344);

        $display("[TB] Inter-byte timeout mid-DATA");
        b_wen = wen_a; b_to = to_a; b_txc = txc_a;
        apply_stimulus(96'({8'hBB, 8'hAA, 8'h10, 8'h01}), 4, 1'b0, 8'h00);
        tick(90);
        check_output("to_not_yet", 64'({busy_a, 8'(to_a - b_to)}), 64'h100);
        tick(20);
        check_output("to_pulses", 64'(to_a - b_to), 64'd1);
        check_output("to_idle", 64'(busy_a), 64'd0);
        check_output("to_no_access", 64'({8'(wen_a - b_wen), 8'(txc_a - b_txc)}), 64'd0);
        write_ok("after_to", 8'h10, 32'hDEADBEEF);

        $display("[TB] rx_err mid-ADDR");
        b_wen = wen_a; b_txc = txc_a;
        apply_stimulus(96'(8'h01), 1, 1'b0, 8'h00);
        tick(3);
        rx_data = 8'h10; rx_valid = 1'b1; rx_err = 1'b1;
        tick(1);
        rx_valid = 1'b0; rx_err = 1'b0;
        check_output("rxerr_idle", 64'(busy_a), 64'd0);
        tick(5);
        check_output("rxerr_no_access", 64'({8'(wen_a - b_wen), 8'(txc_a - b_txc)}), 64'd0);
        rx_err = 1'b1;
        tick(1);
        rx_err = 1'b0;
        check_output("rxerr_in_idle", 64'(busy_a), 64'd0);
        write_ok("after_rxerr", 8'h22, 32'hCAFEF00D);

        $display("[TB] Reset during response");
        apply_stimulus(96'({8'h04, 8'h02}), 2, 1'b1, 8'h00);
        tick(2);
        check_output("rst_pre_tx", 64'(tx_valid_a), 64'd1);
        rst = 1'b1;
        #1;
        check_output("rst_outs_a", 64'(outs_a), 64'h0);
        check_output("rst_bufdata_a", buf_wdata_a, 64'h0);
        tick(1);
        rst = 1'b0;
        tick(2);
        write_ok("after_rst", 8'h33, 32'h0BADCAFE);

        $display("[TB] CRC-less instance");
        sel = 1'b1;
        write_ok("b_wr", 8'h30, 32'h01020304);
        b_wen = wen_b; b_to = to_b; b_txc = txc_b;
        apply_stimulus(96'({8'h01, 8'h30, 8'h01}), 3, 1'b0, 8'h00);
        tick(110);
        check_output("b_to_pulses", 64'(to_b - b_to), 64'd1);
        check_output("b_to_no_access", 64'({8'(wen_b - b_wen), 8'(txc_b - b_txc), 7'd0, busy_b}), 64'd0);
        write_ok("b_after_to", 8'h31, 32'h55AA55AA);
        sel = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
